layer_serializer: RTL and testbench
===================================

Name: layer_serializer

Overview:
- Sits directly downstream of a layer's bank of neurons. Captures the NUM_NEURONS parallel neuron outputs of one inference frame.
- Re-emits the captured values serially, one word per clock, as the myinput/myinputValid stream the next layer's neurons consume. Neuron 0 goes first.
- Holds one extra pending frame, so back-to-back frames stream with no gap. Flags overrun and misaligned-valid errors.

Parameters:
- NUM_NEURONS, 30, number of neurons in the producing layer; frame length in words.
- DATA_WIDTH, 16, width of each neuron output word.
- IDX_WIDTH, $clog2(NUM_NEURONS), width of out_index.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- neuron_out  in  NUM_NEURONS*DATA_WIDTH  packed outputs; neuron i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- neuron_valid  in  NUM_NEURONS  per-neuron single-cycle outvalid pulses.
- err_clr  in  1  clears the sticky error flags.
- out_data  out  DATA_WIDTH  serial word; drives next layer myinput.
- out_valid  out  1  drives next layer myinputValid.
- out_index  out  IDX_WIDTH  neuron number of the current out_data.
- out_last  out  1  high with the final word of a frame.
- busy  out  1  high when streaming or when a frame is pending.
- err_overrun  out  1  sticky; a frame was dropped.
- err_misalign  out  1  sticky; a capture arrived with a partial neuron_valid.

Behaviour:
- Reset: every output is 0. State goes to IDLE. Active and pending buffers are invalidated. rst during streaming aborts the frame, and out_valid is 0 on the next cycle.
- Capture event: |neuron_valid is high at a rising edge. The word is taken from all NUM_NEURONS lanes regardless of individual valid bits.
- Misalign: if a capture event occurs with &neuron_valid == 0, set err_misalign. The frame is still captured.
- States:
  - IDLE: no active frame.
  - STREAM: active buffer is being emitted.
- IDLE + capture at edge t: load the active buffer and go to STREAM. out_valid=1, out_index=0, out_data=neuron 0 are all visible after edge t. This is 1-cycle latency.
- STREAM: each edge advances out_index by 1. out_valid stays high continuously; there is no backpressure. out_last=1 when out_index==NUM_NEURONS-1.
- Leaving STREAM, at the edge where the last word is retired:
  - pending valid: move pending into active, out_index=0, stay in STREAM. There is no bubble.
  - capture at that same edge and no pending: load the capture directly into active, no bubble.
  - otherwise: go to IDLE with out_valid=0. out_data holds its last value; out_index and out_last become 0.
- Capture during STREAM, not at the last word:
  - pending empty: store the capture in pending.
  - pending full: drop the new frame and set err_overrun. Pending is unchanged.
- Capture at the last-word edge while pending is full: pending moves to active, the capture moves to pending, and there is no error.
- busy = (state==STREAM) | pending_valid.
- err_clr clears both error flags. An error set and err_clr in the same cycle leaves the flag set, because set wins. rst also clears both flags.
- Counter wrap: out_index never exceeds NUM_NEURONS-1. NUM_NEURONS=1 is legal: out_last is constantly high while out_valid is high.
- Data is passed unmodified. There is no arithmetic and no sign handling.

Decomposition:
- Shared package (fnn_pkg): DATA_WIDTH default, typedef word_t (logic [DATA_WIDTH-1:0]), state enum ser_state_e {IDLE, STREAM}.
- One natural sub-module: frame_buffer. It is a NUM_NEURONS x DATA_WIDTH register array with load and indexed read, instanced twice (active and pending).

Test Plan:
- Single frame: NUM_NEURONS=4, neuron_out={16'h0004,16'h0003,16'h0002,16'h0001}, neuron_valid=4'hF at edge 10. Expect out_valid high on cycles 11-14 with out_data 1,2,3,4 and out_index 0..3. out_last only on cycle 14. busy low from cycle 15.
- Back-to-back: a second capture of 5,6,7,8 at edge 12. Expect cycles 11-18 to stream 1,2,3,4,5,6,7,8 with no out_valid gap. err_overrun stays 0.
- Overrun: captures at edges 10, 11 and 12, with 4 lanes. Expect frames 1 and 2 to stream and the third to be dropped. err_overrun=1 from cycle 13. Pulsing err_clr clears it.
- Last-edge capture with pending full: captures at edges 10, 11 and 14. Expect 12 consecutive valid words (three frames) and no error.
- Misalign: neuron_valid=4'b0111 with data 9,9,9,9. Expect err_misalign=1 and the frame streamed as 9,9,9,9.
- Reset mid-stream: rst at edge 12 during a frame. Expect out_valid=0 and all outputs 0 from cycle 13. A new capture after reset streams normally from index 0.

Source files
------------

// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared types for the feed-forward network datapath
package fnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - one frame of neuron words with whole-frame load and indexed read
module frame_buffer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                              clk,
  input  logic                              load,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] din,
  input  logic [IDX_WIDTH-1:0]              rd_idx,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] q
);

  logic [NUM_NEURONS*DATA_WIDTH-1:0] mem;

  // Validity is tracked by the owner, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      mem <= din;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (rd_idx == IDX_WIDTH'(i)) begin
        rd_data = mem[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign q = mem;

endmodule

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - captures a layer's parallel neuron outputs and streams them one word per clock
module layer_serializer
  import fnn_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]            neuron_valid,
  input  logic                              err_clr,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic [IDX_WIDTH-1:0]              out_index,
  output logic                              out_last,
  output logic                              busy,
  output logic                              err_overrun,
  output logic                              err_misalign
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  ser_state_e state, state_n;
  logic [IDX_WIDTH-1:0]  idx, idx_n;
  logic                  pend_valid, pend_valid_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  act_load, act_from_pend, pend_load;
  logic                  set_ovr, set_mis;
  logic                  cap;

  logic [NUM_NEURONS*DATA_WIDTH-1:0] act_din, pend_q, unused_act_q;
  logic [DATA_WIDTH-1:0]             act_rd, pend_word0;
  logic [IDX_WIDTH-1:0]              act_rd_idx;

  assign cap        = |neuron_valid;
  assign act_din    = act_from_pend ? pend_q : neuron_out;
  assign act_rd_idx = idx + 1'b1;

  frame_buffer #(
    .NUM_NEURONS(NUM_NEURONS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_active (
    .clk    (clk),
    .load   (act_load),
    .din    (act_din),
    .rd_idx (act_rd_idx),
    .rd_data(act_rd),
    .q      (unused_act_q)
  );

  frame_buffer #(
    .NUM_NEURONS(NUM_NEURONS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_pending (
    .clk    (clk),
    .load   (pend_load),
    .din    (neuron_out),
    .rd_idx ('0),
    .rd_data(pend_word0),
    .q      (pend_q)
  );

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    pend_valid_n  = pend_valid;
    data_n        = data_q;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    set_ovr       = 1'b0;
    set_mis       = cap & ~(&neuron_valid);
    case (state)
      IDLE: begin
        if (cap) begin
          act_load = 1'b1;
          state_n  = STREAM;
          idx_n    = '0;
          data_n   = neuron_out[DATA_WIDTH-1:0];
        end
      end
      STREAM: begin
        if (idx == LAST_IDX) begin
          // Retiring the last word frees the pending slot, so a capture here always fits.
          idx_n = '0;
          if (pend_valid) begin
            act_load      = 1'b1;
            act_from_pend = 1'b1;
            data_n        = pend_word0;
            pend_load     = cap;
            pend_valid_n  = cap;
          end else if (cap) begin
            act_load = 1'b1;
            data_n   = neuron_out[DATA_WIDTH-1:0];
          end else begin
            state_n = IDLE;
          end
        end else begin
          idx_n  = idx + 1'b1;
          data_n = act_rd;
          if (cap) begin
            if (!pend_valid) begin
              pend_load    = 1'b1;
              pend_valid_n = 1'b1;
            end else begin
              set_ovr = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      pend_valid   <= 1'b0;
      data_q       <= '0;
      err_overrun  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      pend_valid   <= pend_valid_n;
      data_q       <= data_n;
      err_overrun  <= (err_overrun & ~err_clr) | set_ovr;
      err_misalign <= (err_misalign & ~err_clr) | set_mis;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state == STREAM);
  assign out_index = idx;
  assign out_last  = (state == STREAM) && (idx == LAST_IDX);
  assign busy      = (state == STREAM) | pend_valid;

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - randomized bench for layer_serializer against a word-queue reference model
module tb_layer_serializer;
  import fnn_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] neuron_out;
  logic [N-1:0]  neuron_valid;
  logic          err_clr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [1:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          err_overrun;
  logic          err_misalign;

  layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .IDX_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .neuron_out  (neuron_out),
    .neuron_valid(neuron_valid),
    .err_clr     (err_clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t d;
    int    i;
    logic  l;
  } ent_t;

  ent_t  exp_q[$];
  word_t m_data = '0;
  logic  m_ovr  = 1'b0;
  logic  m_mis  = 1'b0;
  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
  endtask

  // Whole frames are queued as words; a capture fits if at most one frame remains after this edge's retire.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic c);
    logic cap;
    logic ovr;
    logic mis;
    rst = r; neuron_valid = v; neuron_out = d; err_clr = c;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_data = '0; m_ovr = 1'b0; m_mis = 1'b0;
    end else begin
      cap = |v;
      ovr = 1'b0;
      mis = cap && (v != {N{1'b1}});
      if (exp_q.size() > 0) begin
        m_data = exp_q[0].d;
        void'(exp_q.pop_front());
      end
      if (cap) begin
        if (exp_q.size() <= N) begin
          for (int k = 0; k < N; k++) exp_q.push_back('{d: d[k*DW +: DW], i: k, l: (k == N-1)});
        end else begin
          ovr = 1'b1;
        end
      end
      m_ovr = (m_ovr & ~c) | ovr;
      m_mis = (m_mis & ~c) | mis;
    end
    #1;
    if (exp_q.size() > 0) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data",  32'(out_data),  32'(exp_q[0].d));
      check("out_index", 32'(out_index), 32'(exp_q[0].i));
      check("out_last",  32'(out_last),  32'(exp_q[0].l));
    end else begin
      check("out_valid", 32'(out_valid), 32'd0);
      check("out_data",  32'(out_data),  32'(m_data));
      check("out_index", 32'(out_index), 32'd0);
      check("out_last",  32'(out_last),  32'd0);
    end
    check("busy",         32'(busy),         32'(exp_q.size() > 0));
    check("err_overrun",  32'(err_overrun),  32'(m_ovr));
    check("err_misalign", 32'(err_misalign), 32'(m_mis));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, {32'($urandom), 32'($urandom)}, 1'b0);
  endtask

  localparam logic [N*DW-1:0] F1 = 64'h0004_0003_0002_0001;
  localparam logic [N*DW-1:0] F2 = 64'h0008_0007_0006_0005;
  localparam logic [N*DW-1:0] F3 = 64'h000c_000b_000a_0009;
  localparam logic [N*DW-1:0] F9 = 64'h0009_0009_0009_0009;

  initial begin
    rst = 1'b1; neuron_valid = '0; neuron_out = '0; err_clr = 1'b0;
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);

    phase = "single";
    idle(6);
    step(1'b0, 4'hF, F1, 1'b0);
    idle(6);

    phase = "back2back";
    step(1'b0, 4'hF, F1, 1'b0);
    idle(1);
    step(1'b0, 4'hF, F2, 1'b0);
    idle(9);

    phase = "overrun";
    step(1'b0, 4'hF, F1, 1'b0);
    step(1'b0, 4'hF, F2, 1'b0);
    step(1'b0, 4'hF, F3, 1'b0);
    idle(8);
    step(1'b0, '0, '0, 1'b1);
    idle(2);

    phase = "last_edge";
    step(1'b0, 4'hF, F1, 1'b0);
    step(1'b0, 4'hF, F2, 1'b0);
    idle(2);
    step(1'b0, 4'hF, F3, 1'b0);
    idle(12);

    phase = "misalign";
    step(1'b0, 4'b0111, F9, 1'b0);
    idle(5);
    step(1'b0, 4'b0001, F2, 1'b1);
    idle(5);
    step(1'b0, '0, '0, 1'b1);
    idle(1);

    phase = "reset_mid";
    step(1'b0, 4'hF, F1, 1'b0);
    idle(1);
    step(1'b1, '0, '0, 1'b0);
    idle(2);
    step(1'b0, 4'hF, F2, 1'b0);
    idle(6);

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] v;
      logic         r;
      logic         c;
      r = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) < 40) begin
        v = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
      end else begin
        v = '0;
      end
      step(r, v, {32'($urandom), 32'($urandom)}, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
